// File: rtl/sr_flop_bank.sv
// sr_flop_bank: a bank of WIDTH independent clocked set/reset flops with
// active-low set and reset requests. Each flop also flags invalid requests.
//
// Parameters
//   WIDTH  number of channels (1..32)
//   MODE   action when set and reset are both asserted:
//          0 hold, 1 set wins, 2 reset wins, 3 toggle
//   CNT_W  width of the invalid-event counter (2..16)
//
// Ports
//   clk      rising-edge clock for all state
//   rst_n    asynchronous active-low reset
//   s_n      per-channel active-low set request
//   r_n      per-channel active-low reset request
//   clr_err  active-high single-cycle clear of err and err_cnt
//   q        registered channel state
//   q_bar    complement of q
//   err      sticky per-channel invalid-request flag
//   err_cnt  saturating count of edges with at least one invalid request
//
// Optional feature: define SR_FLOP_BANK_SYNC_EN to pass s_n and r_n through a
// 2-flop synchroniser per bit. This adds two edges of latency to q, err and
// err_cnt (3 edges total from input change). clr_err is not synchronised.

module sr_flop_bank #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_n,
  input  logic [WIDTH-1:0] r_n,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // Request bits as seen by the flop logic.
  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] r_eff;

`ifdef SR_FLOP_BANK_SYNC_EN
  logic [WIDTH-1:0] s_meta_q;
  logic [WIDTH-1:0] s_sync_q;
  logic [WIDTH-1:0] r_meta_q;
  logic [WIDTH-1:0] r_sync_q;

  // Resetting to all ones means "no request" so reset flushes any in-flight
  // request rather than replaying it after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta_q <= '1;
      s_sync_q <= '1;
      r_meta_q <= '1;
      r_sync_q <= '1;
    end else begin
      s_meta_q <= s_n;
      s_sync_q <= s_meta_q;
      r_meta_q <= r_n;
      r_sync_q <= r_meta_q;
    end
  end

  assign s_eff = s_sync_q;
  assign r_eff = r_sync_q;
`else
  assign s_eff = s_n;
  assign r_eff = r_n;
`endif

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] err_q;
  logic [WIDTH-1:0] err_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;
  logic [WIDTH-1:0] invalid;
  logic             any_invalid;

  assign invalid     = ~s_eff & ~r_eff;
  assign any_invalid = |invalid;

  // Per-channel next state; channels never look at each other's requests.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({s_eff[i], r_eff[i]})
        2'b01:   q_d[i] = 1'b1;
        2'b10:   q_d[i] = 1'b0;
        2'b11:   q_d[i] = q_q[i];
        default: begin
          case (MODE)
            1:       q_d[i] = 1'b1;
            2:       q_d[i] = 1'b0;
            3:       q_d[i] = ~q_q[i];
            default: q_d[i] = q_q[i];
          endcase
        end
      endcase
    end
  end

  // A clear coinciding with an invalid event leaves only that edge's event
  // recorded, so the event is never lost.
  always_comb begin
    err_d     = err_q | invalid;
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_d     = invalid;
      err_cnt_d = any_invalid ? CNT_W'(1) : '0;
    end else if (any_invalid && (err_cnt_q != CntMax)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= '0;
      err_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      q_q       <= q_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // q_bar is derived combinationally so it can never disagree with q.
  assign q       = q_q;
  assign q_bar   = ~q_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Testbench for sr_flop_bank. Five instances share the same stimulus:
// MODE 0..3 with CNT_W=8, and MODE 0 with CNT_W=2 for counter saturation.
// A behavioural model predicts every output after each clock edge.

module tb_sr_flop_bank;

  localparam int N = 5;
`ifdef SR_FLOP_BANK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s_n = 4'hF;
  logic [3:0] r_n = 4'hF;
  logic       clr_err = 1'b0;

  logic [3:0] q_w   [N];
  logic [3:0] qb_w  [N];
  logic [3:0] err_w [N];
  logic [7:0] cnt_w [N];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int unsigned CW = (k == 4) ? 2 : 8;
    localparam int unsigned MD = (k < 4) ? k : 0;
    logic [3:0]    q_l;
    logic [3:0]    qb_l;
    logic [3:0]    err_l;
    logic [CW-1:0] cnt_l;

    sr_flop_bank #(
      .WIDTH(4),
      .MODE (MD),
      .CNT_W(CW)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .s_n    (s_n),
      .r_n    (r_n),
      .clr_err(clr_err),
      .q      (q_l),
      .q_bar  (qb_l),
      .err    (err_l),
      .err_cnt(cnt_l)
    );

    assign q_w[k]   = q_l;
    assign qb_w[k]  = qb_l;
    assign err_w[k] = err_l;
    assign cnt_w[k] = 8'(cnt_l);
  end

  // Reference model state
  logic [3:0] mq   [N];
  logic [3:0] merr [N];
  int         mcnt [N];
  logic [3:0] hs   [3];
  logic [3:0] hr   [3];

  function automatic int mode_of(int k);
    return (k < 4) ? k : 0;
  endfunction

  function automatic int cmax_of(int k);
    return (k == 4) ? 3 : 255;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k]   = 4'h0;
      merr[k] = 4'h0;
      mcnt[k] = 0;
    end
    for (int j = 0; j < 3; j++) begin
      hs[j] = 4'hF;
      hr[j] = 4'hF;
    end
  endtask

  // One rising edge with rst_n high. Requests reach the flops LAT-1 edges late.
  task automatic model_edge();
    logic [3:0] es, er, inv;
    hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = s_n;
    hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = r_n;
    es = hs[LAT-1];
    er = hr[LAT-1];
    inv = 4'h0;
    for (int i = 0; i < 4; i++) if (!es[i] && !er[i]) inv[i] = 1'b1;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (inv[i]) begin
          if (mode_of(k) == 1) mq[k][i] = 1'b1;
          else if (mode_of(k) == 2) mq[k][i] = 1'b0;
          else if (mode_of(k) == 3) mq[k][i] = ~mq[k][i];
        end else if (!es[i]) begin
          mq[k][i] = 1'b1;
        end else if (!er[i]) begin
          mq[k][i] = 1'b0;
        end
      end
      if (clr_err) begin
        merr[k] = inv;
        mcnt[k] = (inv != 0) ? 1 : 0;
      end else begin
        merr[k] = merr[k] | inv;
        if (inv != 0 && mcnt[k] < cmax_of(k)) mcnt[k] = mcnt[k] + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      assert (q_w[k] === mq[k]) else begin
        n_fail++;
        $error("FAIL %s q inst%0d observed=%h expected=%h", tag, k, q_w[k], mq[k]);
      end
      n_cmp++;
      assert (qb_w[k] === ~mq[k]) else begin
        n_fail++;
        $error("FAIL %s q_bar inst%0d observed=%h expected=%h", tag, k, qb_w[k], ~mq[k]);
      end
      n_cmp++;
      assert (err_w[k] === merr[k]) else begin
        n_fail++;
        $error("FAIL %s err inst%0d observed=%h expected=%h", tag, k, err_w[k], merr[k]);
      end
      n_cmp++;
      assert (cnt_w[k] === 8'(mcnt[k])) else begin
        n_fail++;
        $error("FAIL %s err_cnt inst%0d observed=%0d expected=%0d", tag, k, cnt_w[k], mcnt[k]);
      end
    end
  endtask

  // Drive inputs, take one edge, check 1 time unit after it.
  task automatic step(input logic [3:0] s, input logic [3:0] r, input logic c,
                      input string tag);
    s_n = s;
    r_n = r;
    clr_err = c;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int j = 0; j < n; j++) step(4'hF, 4'hF, 1'b0, tag);
  endtask

  // Assert reset between edges and check outputs before any edge arrives.
  task automatic mid_cycle_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    step(4'h0, 4'h0, 1'b1, "in_reset_a");
    step(4'h3, 4'hC, 1'b0, "in_reset_b");
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset_init");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single set then single reset on channel 0
    step(4'b1110, 4'b1111, 1'b0, "set_ch0");
    step(4'b1111, 4'b1110, 1'b0, "reset_ch0");
    idle(LAT, "set_reset_flush");

    // Load 0101 then assert both requests everywhere
    step(4'b1010, 4'b0101, 1'b0, "load_0101");
    idle(LAT - 1, "load_flush");
    step(4'h0, 4'h0, 1'b0, "both_low");
    idle(LAT - 1, "both_low_flush");
    step(4'hF, 4'hF, 1'b1, "clear_after_mode");

    // Saturation: invalid on channel 0 for five edges
    for (int j = 0; j < 5; j++) step(4'b1110, 4'b1110, 1'b0, "sat");
    idle(LAT - 1, "sat_flush");

    // Clear colliding with an invalid event on channel 2 (aligned with the
    // edge at which that event reaches the flops)
    step(4'b1011, 4'b1011, (LAT == 1), "collide_a");
    if (LAT > 1) begin
      step(4'hF, 4'hF, 1'b0, "collide_b");
      step(4'hF, 4'hF, 1'b1, "collide_c");
    end
    step(4'hF, 4'hF, 1'b1, "clr_alone");

    // Set on channel 3 to observe input-to-q latency
    step(4'b0111, 4'hF, 1'b0, "latency");
    idle(LAT, "latency_flush");

    // Load 1010 and reset asynchronously mid-cycle
    step(4'b0101, 4'b1010, 1'b0, "load_1010");
    idle(LAT - 1, "load_1010_flush");
    mid_cycle_reset("async_reset");

    // Randomised traffic with occasional clears and resets
    for (int j = 0; j < 300; j++) begin
      logic [3:0] s, r;
      logic       c;
      s = 4'($urandom);
      r = 4'($urandom);
      c = ($urandom_range(0, 7) == 0);
      step(s, r, c, "random");
      if ($urandom_range(0, 59) == 0) mid_cycle_reset("random_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
